// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline registers.
//   pipe_state_e : occupancy state of a skid-buffered stage register
//   *_DEF        : default instruction / next-PC widths and bubble value
//   PERF_CNT_W   : width of the optional performance counters
//   sat_inc()    : saturating increment for those counters
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam int unsigned INST_W_DEF   = 32;
    localparam int unsigned PC_W_DEF     = 10;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam int unsigned PERF_CNT_W   = 16;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry {valid, inst, npc} with load and clear.
// A cleared (or reset) entry holds the bubble pattern: valid=0, inst=NOP_INST, npc=0,
// so downstream logic can drive its outputs straight from the register.
// Ports:
//   clk, reset (sync, active-low)
//   clear            : empty the entry (wins over load)
//   load             : capture load_inst/load_npc and mark valid
//   load_inst, load_npc
//   valid, inst, npc : registered contents
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [INST_W-1:0] load_inst,
    input  logic [PC_W-1:0]   load_npc,
    output logic              valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   npc
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            npc   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            npc   <= load_npc;
        end
    end

endmodule

// File: rtl/if_id_pipe_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer and flush.
// Carries {instruction, next-PC} from fetch to decode over valid/ready. in_ready comes
// directly from the skid entry's valid flop, so a decode stall never reaches fetch
// combinationally. Outputs come only from the main entry; a bubble reads as NOP_INST/0.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid, in_ready, inst_in, npc_in     : fetch side
//   out_valid, out_ready, inst_out, npc_out : decode side
//   flush                                    : drop held and incoming entries
// Optional (define IF_ID_PERF_CNT_EN):
//   stall_cnt : cycles with out_valid & !out_ready, saturating
//   flush_cnt : cycles with flush asserted, saturating
module if_id_pipe_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter int unsigned       PC_W     = PC_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_W-1:0]     inst_in,
    input  logic [PC_W-1:0]       npc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_W-1:0]     inst_out,
    output logic [PC_W-1:0]       npc_out,
    input  logic                  flush
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_e state_q, state_d;

    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_valid, skid_valid;
    logic [INST_W-1:0] main_inst, skid_inst, main_load_inst;
    logic [PC_W-1:0]   main_npc, skid_npc, main_load_npc;
    logic              in_xfer, out_xfer;

    // The skid entry is occupied exactly in SKID, the only state refusing input.
    assign in_ready = ~skid_valid;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            // Same-cycle input is swallowed; a same-cycle output transfer already happened.
            state_d    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d    = EMPTY;
                        main_clear = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        state_d        = FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_load_inst = main_from_skid ? skid_inst : inst_in;
    assign main_load_npc  = main_from_skid ? skid_npc  : npc_in;

    pipe_entry_reg #(
        .INST_W   (INST_W),
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .clear     (main_clear),
        .load      (main_load),
        .load_inst (main_load_inst),
        .load_npc  (main_load_npc),
        .valid     (main_valid),
        .inst      (main_inst),
        .npc       (main_npc)
    );

    pipe_entry_reg #(
        .INST_W   (INST_W),
        .PC_W     (PC_W),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_inst (inst_in),
        .load_npc  (npc_in),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .npc       (skid_npc)
    );

    assign out_valid = main_valid;
    assign inst_out  = main_inst;
    assign npc_out   = main_npc;

`ifdef IF_ID_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid && !out_ready) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (flush) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // Counters not built.
`endif

endmodule

// File: tb/tb_if_id_pipe_skid.sv
// Testbench for if_id_pipe_skid: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Also exercises a 16/12-bit build with a non-zero bubble value.
// Define IF_ID_PERF_CNT_EN to include the performance counter checks.
module tb_if_id_pipe_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] inst_in, inst_out;
    logic [9:0]  npc_in, npc_out;
`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    // Parametrised instance
    logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_flush;
    logic [15:0] p_inst_in, p_inst_out;
    logic [11:0] p_npc_in, p_npc_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_pipe_skid dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_in   (inst_in),
        .npc_in    (npc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .npc_out   (npc_out),
        .flush     (flush)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    if_id_pipe_skid #(
        .INST_W   (16),
        .PC_W     (12),
        .NOP_INST (16'h7000)
    ) dut_p (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .inst_in   (p_inst_in),
        .npc_in    (p_npc_in),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .inst_out  (p_inst_out),
        .npc_out   (p_npc_out),
        .flush     (p_flush)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt (),
        .flush_cnt ()
`endif
    );

    // Reference model: the stage is a FIFO of at most two {inst, npc} entries.
    typedef struct {
        logic [31:0] inst;
        logic [9:0]  npc;
    } ent_t;
    ent_t model_q[$];
    int   m_stall = 0;
    int   m_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit   oxf, ixf;
        ent_t e;
        if (!reset) begin
            model_q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (model_q.size() > 0 && !out_ready && m_stall < 16'hFFFF) m_stall++;
            if (flush && m_flush < 16'hFFFF) m_flush++;
            if (flush) begin
                model_q.delete();
            end else begin
                oxf = (model_q.size() > 0) && out_ready;
                ixf = in_valid && (model_q.size() < 2);
                if (oxf) void'(model_q.pop_front());
                if (ixf) begin
                    e.inst = inst_in;
                    e.npc  = npc_in;
                    model_q.push_back(e);
                end
            end
        end
    endtask

    task automatic compare();
        logic        ev;
        logic [31:0] ei;
        logic [9:0]  en;
        ev = model_q.size() > 0;
        ei = ev ? model_q[0].inst : 32'h0;
        en = ev ? model_q[0].npc : 10'h0;
        chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
        chk("in_ready", {31'b0, in_ready}, {31'b0, model_q.size() < 2});
        chk("inst_out", inst_out, ei);
        chk("npc_out", {22'b0, npc_out}, {22'b0, en});
`ifdef IF_ID_PERF_CNT_EN
        chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
        chk("flush_cnt", {16'b0, flush_cnt}, m_flush);
`endif
    endtask

    // Advance one clock: update model at the edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic iv, input logic [31:0] ii, input logic [9:0] pn,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        inst_in   = ii;
        npc_in    = pn;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 32'h99, 10'd9, 1'b0, 1'b0);
        p_in_valid = 1'b0; p_inst_in = 16'h0; p_npc_in = 12'h0;
        p_out_ready = 1'b1; p_flush = 1'b0;

        // Reset held two cycles with in_valid high
        step();
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_npc", {22'b0, npc_out}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("p_idle_inst", {16'b0, p_inst_out}, 32'h7000);
        chk("p_idle_valid", {31'b0, p_out_valid}, 32'd0);
        reset = 1'b1;
        drive(1'b1, 32'h55, 10'd5, 1'b0, 1'b0);
        step();
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_inst", inst_out, 32'h55);

        // Streaming
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h11 * (i + 1), 10'(i + 1), 1'b1, 1'b0);
            step();
            chk("stream_inst", inst_out, 32'h11 * (i + 1));
            chk("stream_npc", {22'b0, npc_out}, i + 1);
            chk("stream_ready", {31'b0, in_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Stall into skid
        drive(1'b1, 32'hA1, 10'h0A1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hA2, 10'h0A2, 1'b0, 1'b0);
        step();
        chk("skid_in_ready", {31'b0, in_ready}, 32'd0);
        chk("skid_hold", inst_out, 32'hA1);
        drive(1'b0, 32'h0, 10'd0, 1'b0, 1'b0);
        step();
        chk("skid_stable", inst_out, 32'hA1);
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        step();
        chk("skid_second", inst_out, 32'hA2);
        chk("skid_ready_back", {31'b0, in_ready}, 32'd1);
        step();
        chk("skid_empty", {31'b0, out_valid}, 32'd0);

        // Flush in SKID with an incoming word
        drive(1'b1, 32'hB1, 10'd1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB2, 10'd2, 1'b0, 1'b0);
        step();
        chk("pre_flush_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'hB3, 10'd3, 1'b0, 1'b1);
        step();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_inst", inst_out, 32'h0);
        chk("flush_npc", {22'b0, npc_out}, 32'd0);
        chk("flush_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        step();
        chk("flush_no_b3", {31'b0, out_valid}, 32'd0);

        // Parametrised build: wide next-PC passes untruncated
        p_in_valid = 1'b1; p_inst_in = 16'hBEEF; p_npc_in = 12'hFFF;
        step();
        p_in_valid = 1'b0;
        chk("p_valid", {31'b0, p_out_valid}, 32'd1);
        chk("p_inst", {16'b0, p_inst_out}, 32'hBEEF);
        chk("p_npc", {20'b0, p_npc_out}, 32'hFFF);
        chk("p_ready", {31'b0, p_in_ready}, 32'd1);
        step();
        chk("p_bubble", {16'b0, p_inst_out}, 32'h7000);

`ifdef IF_ID_PERF_CNT_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        drive(1'b1, 32'hC1, 10'd1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 10'd0, 1'b0, 1'b0);
        repeat (5) step();
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b1);
        step();
        step();
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        step();
        chk("perf_stall5", {16'b0, stall_cnt}, 32'd5);
        chk("perf_flush2", {16'b0, flush_cnt}, 32'd2);
        // Preload near the top to reach saturation quickly
        dut.stall_cnt_q = 16'hFFFE;
        dut.flush_cnt_q = 16'hFFFF;
        m_stall = 16'hFFFE;
        m_flush = 16'hFFFF;
        drive(1'b1, 32'hC2, 10'd2, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 10'd0, 1'b0, 1'b0);
        repeat (3) step();
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b1);
        step();
        chk("perf_stall_sat", {16'b0, stall_cnt}, 32'hFFFF);
        chk("perf_flush_sat", {16'b0, flush_cnt}, 32'hFFFF);
        drive(1'b0, 32'h0, 10'd0, 1'b1, 1'b0);
        step();
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset     = ($urandom % 64) != 0;
            in_valid  = ($urandom % 4) != 0;
            inst_in   = $urandom;
            npc_in    = 10'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 16) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
